// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
//   Host-side handshake bundle for spi_master.
//   Ports (per modport):
//     master : drives start/data_in, observes busy/done/rx   (host logic)
//     slave  : observes start/data_in, drives busy/done/rx   (spi_master)
//   start    request a frame (sampled only while the master is idle)
//   data_in  word to transmit, captured on the accepting cycle
//   busy     high from start accept through the done cycle
//   done     one-cycle pulse at frame end
//   rx       last received word, updated together with done
// -----------------------------------------------------------------------------
interface spi_master_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  rx
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output rx
    );
endinterface

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-word, full-duplex, MSB-first SPI initiator.  The host loads a word
//   and pulses start; the block frames it with CS, generates SCLK from the
//   system clock and returns the word shifted in from MISO together with a
//   one-cycle done pulse.
//
//   Parameters
//     MODE        {CPOL,CPHA}; CPOL = SCLK idle level, CPHA = 1 shifts on the
//                 leading edge and samples on the trailing edge
//     DATA_WIDTH  bits per frame (2..16)
//     CLK_DIV     clk cycles per SCLK half-period (>= 1)
//
//   Ports
//     clk    system clock, rising edge
//     rst_n  synchronous reset, active low
//     host   spi_master_if.slave : start, data_in, busy, done, rx
//     MISO   serial data from the slave
//     SCLK   serial clock, idles at CPOL
//     CS     chip select, active low
//     MOSI   serial data to the slave
//
//   Frame timing: CS is low for (2*DATA_WIDTH+2)*CLK_DIV cycles: CLK_DIV
//   cycles of setup, 2*DATA_WIDTH SCLK half-periods, CLK_DIV cycles of hold.
//   done rises on the same edge that releases CS; busy drops one cycle later.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter logic [1:0] MODE       = 2'd3,
    parameter int         DATA_WIDTH = 8,
    parameter int         CLK_DIV    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  host,
    input  logic         MISO,
    output logic         SCLK,
    output logic         CS,
    output logic         MOSI
);

    localparam logic CPOL = MODE[1];
    localparam logic CPHA = MODE[0];

    // Divider counter counts 0..CLK_DIV-1; keep at least one bit for CLK_DIV=1.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Edge counter counts SCLK toggles 0..2*DATA_WIDTH-1.
    localparam int EW = $clog2(2 * DATA_WIDTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t                state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [EW-1:0]         edge_q,   edge_d;
    logic [DATA_WIDTH-1:0] tx_q,     tx_d;
    logic [DATA_WIDTH-1:0] rxsh_q,   rxsh_d;
    logic [DATA_WIDTH-1:0] rx_q,     rx_d;
    logic                  sclk_q,   sclk_d;
    logic                  cs_q,     cs_d;
    logic                  mosi_q,   mosi_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic                  wrap_s;
    logic                  leading_s;

    // Divider wrap marks the end of a setup/hold period or an SCLK half-period.
    always_comb begin
        wrap_s    = (cnt_q == CNT_LAST);
        // Even toggle indices move SCLK away from CPOL (leading edges).
        leading_s = ~edge_q[0];
    end

    // Next-state and next-output computation for the whole frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rxsh_d  = rxsh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // busy covers the done cycle, then drops.
                if (done_q) begin
                    busy_d = 1'b0;
                end else begin
                    busy_d = busy_q;
                end
                // start is ignored while busy is still high (done cycle).
                if (host.start && !busy_q) begin
                    tx_d    = host.data_in;
                    rxsh_d  = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    edge_d  = '0;
                    sclk_d  = CPOL;
                    state_d = ST_SETUP;
                    // CPHA=0 slaves sample on the first edge, so the MSB must
                    // be on the wire as soon as CS falls.
                    if (CPHA) begin
                        mosi_d = 1'b0;
                    end else begin
                        mosi_d = host.data_in[DATA_WIDTH-1];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (wrap_s) begin
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            ST_XFER: begin
                if (wrap_s) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EW'(1);
                    if (leading_s) begin
                        if (CPHA) begin
                            mosi_d = tx_q[DATA_WIDTH-1];
                            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            rxsh_d = {rxsh_q[DATA_WIDTH-2:0], MISO};
                        end
                    end else begin
                        if (CPHA) begin
                            rxsh_d = {rxsh_q[DATA_WIDTH-2:0], MISO};
                        end else if (edge_q != EDGE_LAST) begin
                            // Present the next bit; the last trailing edge
                            // leaves the final bit on the wire through HOLD.
                            mosi_d = tx_q[DATA_WIDTH-2];
                            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                        end else begin
                            mosi_d = mosi_q;
                        end
                    end
                    if (edge_q == EDGE_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_HOLD: begin
                if (wrap_s) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    rx_d    = rxsh_q;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                edge_d  = '0;
                sclk_d  = CPOL;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rxsh_q  <= '0;
            rx_q    <= '0;
            sclk_q  <= CPOL;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rxsh_q  <= rxsh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCLK      = sclk_q;
    assign CS        = cs_q;
    assign MOSI      = mosi_q;
    assign host.busy = busy_q;
    assign host.done = done_q;
    assign host.rx   = rx_q;

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;

    localparam int W  = 8;
    localparam int NI = 3;

    // Instance 0: MODE 3 / div 2, instance 1: MODE 0 / div 2, instance 2: MODE 1 / div 1.
    function automatic logic [1:0] mode_of(input int k);
        case (k)
            0:       return 2'd3;
            1:       return 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    function automatic int div_of(input int k);
        case (k)
            0:       return 2;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic cpol_of(input int k);
        logic [1:0] m;
        m = mode_of(k);
        return m[1];
    endfunction

    logic clk = 1'b0;
    logic rst_n;

    logic [NI-1:0] start_v;
    logic [NI-1:0] busy_v;
    logic [NI-1:0] done_v;
    logic [NI-1:0] sclk_v;
    logic [NI-1:0] cs_v;
    logic [NI-1:0] mosi_v;
    logic [W-1:0]  din_a  [NI];
    logic [W-1:0]  rx_a   [NI];
    logic [W-1:0]  resp_a [NI];

    // Scoreboard: {expected rx, expected MOSI word} per accepted frame.
    logic [2*W-1:0] exp_q [NI][$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam logic [1:0] M    = mode_of(g);
        localparam int         D    = div_of(g);
        localparam logic       CPOL = M[1];
        localparam logic       CPHA = M[0];

        spi_master_if #(.DATA_WIDTH(W)) bus ();
        logic           miso = 1'b0;
        logic [W-1:0]   s_tx;
        logic [W-1:0]   s_rx;
        int             s_tog  = 0;
        int             cs_low = 0;
        logic [2*W-1:0] e;

        assign bus.start   = start_v[g];
        assign bus.data_in = din_a[g];
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign rx_a[g]     = bus.rx;

        spi_master #(.MODE(M), .DATA_WIDTH(W), .CLK_DIV(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .host  (bus),
            .MISO  (miso),
            .SCLK  (sclk_v[g]),
            .CS    (cs_v[g]),
            .MOSI  (mosi_v[g])
        );

        // Slave model: load the response when selected.
        always @(negedge cs_v[g]) begin
            s_tx  = resp_a[g];
            s_rx  = '0;
            s_tog = 0;
            if (!CPHA) begin
                miso = s_tx[W-1];
                s_tx = {s_tx[W-2:0], 1'b0};
            end else begin
                miso = 1'b0;
            end
        end

        // Slave model: shift on one SCLK edge, sample MOSI on the other.
        always @(sclk_v[g]) begin
            if (cs_v[g] === 1'b0) begin
                s_tog++;
                if ((sclk_v[g] != CPOL) == CPHA) begin
                    miso = s_tx[W-1];
                    s_tx = {s_tx[W-2:0], 1'b0};
                end else begin
                    s_rx = {s_rx[W-2:0], mosi_v[g]};
                end
            end
        end

        // Monitor: count CS-low cycles and score each done pulse.
        always @(negedge clk) begin
            if (!rst_n) begin
                cs_low = 0;
            end else begin
                if (cs_v[g] === 1'b0) cs_low++;
                if (done_v[g] === 1'b1) begin
                    if (exp_q[g].size() == 0) begin
                        check("unexpected_done", 32'(g), 32'(NI));
                    end else begin
                        e = exp_q[g].pop_front();
                        check("rx",        32'(rx_a[g]),  32'(e[2*W-1:W]));
                        check("mosi_word", 32'(s_rx),     32'(e[W-1:0]));
                        check("cs_low",    32'(cs_low),   32'((2*W+2)*D));
                        check("toggles",   32'(s_tog),    32'(2*W));
                        check("cs_release",32'(cs_v[g]),  32'd1);
                        check("sclk_idle", 32'(sclk_v[g]),32'(CPOL));
                    end
                    cs_low = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (busy_v[k] !== 1'b0 && n < 200) begin
            tick(1);
            n++;
        end
        check("idle_wait", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_drained(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("done_wait", 32'(n < 300), 32'd1);
        tick(2);
    endtask

    task automatic send(input int k, input logic [W-1:0] data, input logic [W-1:0] resp);
        wait_idle(k);
        resp_a[k]  = resp;
        din_a[k]   = data;
        start_v[k] = 1'b1;
        tick(1);
        start_v[k] = 1'b0;
        exp_q[k].push_back({resp, data});
        check("busy_accept", 32'(busy_v[k]), 32'd1);
        check("cs_accept",   32'(cs_v[k]),   32'd0);
        check("sclk_accept", 32'(sclk_v[k]), 32'(cpol_of(k)));
    endtask

    initial begin
        int gap;
        int n;
        start_v = '0;
        for (int k = 0; k < NI; k++) begin
            din_a[k]  = '0;
            resp_a[k] = '0;
        end
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Reset state of every instance.
        for (int k = 0; k < NI; k++) begin
            check("rst_cs",   32'(cs_v[k]),   32'd1);
            check("rst_sclk", 32'(sclk_v[k]), 32'(cpol_of(k)));
            check("rst_mosi", 32'(mosi_v[k]), 32'd0);
            check("rst_busy", 32'(busy_v[k]), 32'd0);
            check("rst_done", 32'(done_v[k]), 32'd0);
            check("rst_rx",   32'(rx_a[k]),   32'd0);
        end

        // T1: MODE 3, divide by 2.
        send(0, 8'hB3, 8'hCA);
        wait_drained(0);

        // T2: MODE 0.
        send(1, 8'h5A, 8'h3C);
        wait_drained(1);

        // T3: second start mid-frame is ignored.
        send(0, 8'h3D, 8'hA5);
        tick(9);
        din_a[0]   = 8'hFF;
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        check("t3_busy", 32'(busy_v[0]), 32'd1);
        wait_drained(0);
        tick(10);
        check("t3_no_requeue_cs",   32'(cs_v[0]),   32'd1);
        check("t3_no_requeue_busy", 32'(busy_v[0]), 32'd0);

        // T4: reset during half-period 7 aborts the frame.
        send(0, 8'h71, 8'h2E);
        tick(15);
        check("t4_busy_before", 32'(busy_v[0]), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_q[0].delete();
        check("t4_cs",   32'(cs_v[0]),   32'd1);
        check("t4_sclk", 32'(sclk_v[0]), 32'd1);
        check("t4_busy", 32'(busy_v[0]), 32'd0);
        check("t4_done", 32'(done_v[0]), 32'd0);
        check("t4_rx",   32'(rx_a[0]),   32'd0);
        tick(60);
        check("t4_idle_cs", 32'(cs_v[0]), 32'd1);

        // T5: start held high, two frames back to back.
        wait_idle(0);
        resp_a[0]  = 8'h5C;
        din_a[0]   = 8'h01;
        start_v[0] = 1'b1;
        tick(1);
        exp_q[0].push_back({8'h5C, 8'h01});
        din_a[0]  = 8'h80;
        resp_a[0] = 8'hE7;
        exp_q[0].push_back({8'hE7, 8'h80});
        n = 0;
        while (done_v[0] !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("t5_first_done", 32'(n < 200), 32'd1);
        gap = 0;
        n   = 0;
        tick(1);
        while (cs_v[0] !== 1'b0 && n < 10) begin
            if (busy_v[0] === 1'b0) gap++;
            tick(1);
            n++;
        end
        start_v[0] = 1'b0;
        // One idle cycle (CS high, busy low) between the done cycle and the next frame.
        check("t5_gap", 32'(gap), 32'd1);
        wait_drained(0);

        // T6: MODE 1, divide by 1.
        send(2, 8'hC6, 8'h1B);
        wait_drained(2);
        send(2, 8'h81, 8'h7E);
        wait_drained(2);

        // Extra MODE 0 pattern with alternating edges.
        send(1, 8'hAA, 8'h55);
        wait_drained(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
